sc_nand_unit: RTL and testbench

- Stochastic-computing NAND tile with two Sobol-based stochastic number generators (SNGs) and one bitwise NAND stage.
- Each SNG converts a 6-bit probability (value/64) into a 32-bit bitstream using a 6-dimension-number Sobol low-discrepancy sequence.
- The NAND stage combines the two streams bit by bit. Its output stream encodes 1 − pA·pB.
- The tile is the basic gate for stochastic-logic datapaths in the VLSI project.

---
 rtl/sc_nand_unit.sv | 178 +++++++++++++++++
 tb/tb_sc_nand_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sc_nand_unit.sv
// Stochastic-computing NAND tile: two Sobol-driven stochastic number
// generators feeding a bitwise NAND stage that publishes once both streams
// are complete.

// Sobol-sequence stochastic number generator: one bitstream bit per enabled
// step, one-shot until reset.
module sc_sng #(
    parameter int unsigned LEN = 32,
    parameter int unsigned RES = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_in,
    input  logic [RES-1:0]     num,
    input  logic [RES*RES-1:0] m,
    output logic [LEN-1:0]     seq,
    output logic               done
);

    localparam int unsigned IW = (LEN > 1) ? $clog2(LEN) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic                      step;
    logic [IW-1:0]             idx_q;
    logic [RES-1:0]            x_q;
    logic [RES-1:0]            num_q, num_cur;
    logic [RES-1:0][RES-1:0]   m_q, m_cur, v_cur;
    logic [RES-1:0]            dir;
    logic                      hit;
    logic [LEN-1:0]            seq_q;

    // Step 0 uses the live inputs (they are latched on that same edge);
    // later steps use the latched copies.
    always_comb begin
        num_cur = (state_q == S_IDLE) ? num : num_q;
        m_cur   = (state_q == S_IDLE) ? m   : m_q;
        for (int unsigned k = 0; k < RES; k++) begin
            v_cur[k] = m_cur[k] << (RES - 1 - k);
        end
    end

    // Gray-code Sobol: the direction vector is picked by the trailing-ones
    // count of the current step index, i.e. the position of its lowest zero.
    always_comb begin
        dir = '0;
        hit = 1'b0;
        for (int unsigned b = 0; b < IW; b++) begin
            if (!hit && !idx_q[b]) begin
                hit = 1'b1;
                if (b < RES) begin
                    dir = v_cur[b];
                end
            end
        end
    end

    // Next-state logic: idle until the first enabled edge, run LEN steps, then stop.
    always_comb begin
        state_d = state_q;
        step    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en_in) begin
                    step    = 1'b1;
                    state_d = (idx_q == IW'(LEN - 1)) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (en_in) begin
                    step = 1'b1;
                    if (idx_q == IW'(LEN - 1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: latch operands at step 0, emit one comparison bit per step.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
            x_q   <= '0;
            num_q <= '0;
            m_q   <= '0;
            seq_q <= '0;
        end else if (step) begin
            seq_q[idx_q] <= (x_q < num_cur);
            x_q          <= x_q ^ dir;
            if (state_d != S_DONE) begin
                idx_q <= idx_q + 1'b1;
            end
            if (state_q == S_IDLE) begin
                num_q <= num;
                m_q   <= m;
            end
        end
    end

    assign seq  = seq_q;
    assign done = (state_q == S_DONE);

endmodule

module sc_nand_unit #(
    parameter int unsigned LEN = 32,
    parameter int unsigned RES = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_in,
    input  logic [RES-1:0]     num_a,
    input  logic [RES-1:0]     num_b,
    input  logic [RES*RES-1:0] m_a,
    input  logic [RES*RES-1:0] m_b,
    output logic [LEN-1:0]     seq_a,
    output logic [LEN-1:0]     seq_b,
    output logic [LEN-1:0]     out,
    output logic               en_out
);

    logic done_a, done_b;
    logic [LEN-1:0] out_q;
    logic           en_out_q;

    sc_sng #(.LEN(LEN), .RES(RES)) u_sng_a (
        .clk   (clk),
        .rst   (rst),
        .en_in (en_in),
        .num   (num_a),
        .m     (m_a),
        .seq   (seq_a),
        .done  (done_a)
    );

    sc_sng #(.LEN(LEN), .RES(RES)) u_sng_b (
        .clk   (clk),
        .rst   (rst),
        .en_in (en_in),
        .num   (num_b),
        .m     (m_b),
        .seq   (seq_b),
        .done  (done_b)
    );

    // NAND stage: capture once both streams are complete, then hold until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q    <= '0;
            en_out_q <= 1'b0;
        end else if (done_a && done_b && !en_out_q) begin
            out_q    <= ~(seq_a & seq_b);
            en_out_q <= 1'b1;
        end
    end

    assign out    = out_q;
    assign en_out = en_out_q;

endmodule

// File: tb/tb_sc_nand_unit.sv
// Directed self-checking bench for sc_nand_unit.
module tb_sc_nand_unit;

    localparam int unsigned LEN = 32;
    localparam int unsigned RES = 6;

    logic               clk;
    logic               rst;
    logic               en_in;
    logic [RES-1:0]     num_a, num_b;
    logic [RES*RES-1:0] m_a, m_b;
    logic [LEN-1:0]     seq_a, seq_b, out;
    logic               en_out;

    int n_checks = 0;
    int n_errors = 0;

    // m_1 in the low field: (1,3,5,7,9,11) and (3,5,7,9,11,1)
    localparam logic [35:0] MA  = {6'd11, 6'd9, 6'd7, 6'd5, 6'd3, 6'd1};
    localparam logic [35:0] MB  = {6'd1, 6'd11, 6'd9, 6'd7, 6'd5, 6'd3};
    localparam logic [35:0] MX  = {6'd63, 6'd17, 6'd2, 6'd60, 6'd33, 6'd5};

    sc_nand_unit #(.LEN(LEN), .RES(RES)) dut (
        .clk    (clk),
        .rst    (rst),
        .en_in  (en_in),
        .num_a  (num_a),
        .num_b  (num_b),
        .m_a    (m_a),
        .m_b    (m_b),
        .seq_a  (seq_a),
        .seq_b  (seq_b),
        .out    (out),
        .en_out (en_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference stream straight from the recurrence definition.
    function automatic logic [31:0] sobol_stream(input int num, input logic [35:0] mm);
        int v[1:6];
        int x, c, t;
        logic [31:0] s;
        logic [35:0] tmp;
        tmp = mm;
        for (int k = 1; k <= 6; k++) begin
            v[k] = (int'(tmp[6*(k-1) +: 6]) << (6 - k)) & 63;
        end
        x = 0;
        s = '0;
        for (int i = 0; i < 32; i++) begin
            s[i] = (x < num);
            c = 0;
            t = i;
            while (t[0]) begin
                c++;
                t = t >> 1;
            end
            if (c + 1 <= 6) x = x ^ v[c + 1];
        end
        return s;
    endfunction

    task automatic do_reset();
        rst   = 1'b1;
        en_in = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [31:0] ea, eb;
    int cnt;

    initial begin
        rst = 1'b1; en_in = 1'b0;
        num_a = '0; num_b = '0; m_a = '0; m_b = '0;
        edges(2);
        rst = 1'b0;
        check("reset seq_a", seq_a, 32'h0);
        check("reset seq_b", seq_b, 32'h0);
        check("reset out", out, 32'h0);
        check("reset en_out", {31'b0, en_out}, 32'h0);

        // Main run with latency check
        num_a = 6'd19; m_a = MA; num_b = 6'd51; m_b = MB;
        en_in = 1'b1;
        edges(32);
        check("en_out low at edge 32", {31'b0, en_out}, 32'h0);
        edges(1);
        check("en_out high at edge 33", {31'b0, en_out}, 32'h1);
        ea = sobol_stream(19, MA);
        eb = sobol_stream(51, MB);
        check("seq_a low bits", {27'b0, seq_a[4:0]}, 32'h05);
        check("seq_a stream", seq_a, ea);
        check("seq_b stream", seq_b, eb);
        check("nand out", out, ~(ea & eb));
        for (int i = 0; i < 20; i++) begin
            edges(1);
            check("out held", out, ~(ea & eb));
            check("en_out held", {31'b0, en_out}, 32'h1);
        end
        check("seq_a frozen", seq_a, ea);

        // num = 0 on both sides
        do_reset();
        num_a = 6'd0; num_b = 6'd0; m_a = MX; m_b = MB;
        en_in = 1'b1;
        edges(33);
        check("zero seq_a", seq_a, 32'h0);
        check("zero seq_b", seq_b, 32'h0);
        check("zero out", out, 32'hFFFFFFFF);
        check("zero en_out", {31'b0, en_out}, 32'h1);

        // num = 63
        do_reset();
        num_a = 6'd63; num_b = 6'd63; m_a = MA; m_b = MX;
        en_in = 1'b1;
        edges(33);
        check("max seq_a", seq_a, sobol_stream(63, MA));
        check("max seq_b", seq_b, sobol_stream(63, MX));

        // Five-cycle pause mid-run delays en_out by five cycles
        do_reset();
        num_a = 6'd19; m_a = MA; num_b = 6'd51; m_b = MB;
        en_in = 1'b1;
        edges(10);
        en_in = 1'b0;
        edges(5);
        check("pause en_out low", {31'b0, en_out}, 32'h0);
        en_in = 1'b1;
        cnt = 15;
        while (!en_out && cnt < 80) begin
            edges(1);
            cnt++;
        end
        check("pause latency", cnt, 38);
        check("pause seq_a", seq_a, ea);
        check("pause seq_b", seq_b, eb);

        // Reset at step 10 aborts; rerun matches a clean run
        do_reset();
        num_a = 6'd19; m_a = MA; num_b = 6'd51; m_b = MB;
        en_in = 1'b1;
        edges(10);
        rst = 1'b1;
        edges(1);
        check("abort seq_a", seq_a, 32'h0);
        check("abort seq_b", seq_b, 32'h0);
        check("abort out", out, 32'h0);
        check("abort en_out", {31'b0, en_out}, 32'h0);
        rst = 1'b0;
        num_a = 6'd51;
        edges(33);
        check("rerun seq_a", seq_a, sobol_stream(51, MA));
        check("rerun en_out", {31'b0, en_out}, 32'h1);

        // Inputs changed after step 0 are ignored
        do_reset();
        num_a = 6'd19; m_a = MA; num_b = 6'd51; m_b = MB;
        en_in = 1'b1;
        edges(1);
        num_a = 6'd50; m_a = MX; num_b = 6'd3; m_b = MX;
        edges(32);
        check("latched seq_a", seq_a, ea);
        check("latched seq_b", seq_b, eb);
        check("latched out", out, ~(ea & eb));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
